// File: rtl/motion_update_broadcaster.sv
// Motion-update transmitter: sweeps every cell of the position caches and broadcasts each
// particle with its destination cell. Define MU_BROADCAST_PERIODIC_WRAP_EN for periodic wrap.

module mu_axis_dst #(
    parameter int DATA_WIDTH    = 32,
    parameter int CELL_ID_WIDTH = 4,
    parameter int CELL_NUM      = 3
) (
    input  logic [DATA_WIDTH-1:0]    pos_i,
    output logic [DATA_WIDTH-1:0]    pos_o,
    output logic [CELL_ID_WIDTH-1:0] cell_o,
    output logic                     ok_o
);
    logic [CELL_ID_WIDTH-1:0] c;
    assign c = pos_i[DATA_WIDTH-1 -: CELL_ID_WIDTH];

    always_comb begin
        pos_o  = pos_i;
        cell_o = c;
        ok_o   = 1'b0;
        if (c != '0 && int'(c) <= CELL_NUM) begin
            ok_o = 1'b1;
        end
`ifdef MU_BROADCAST_PERIODIC_WRAP_EN
        // One cell past either face wraps to the opposite face.
        else if (c == '0) begin
            ok_o   = 1'b1;
            cell_o = CELL_ID_WIDTH'(CELL_NUM);
            pos_o[DATA_WIDTH-1 -: CELL_ID_WIDTH] = CELL_ID_WIDTH'(CELL_NUM);
        end else if (int'(c) == CELL_NUM + 1) begin
            ok_o   = 1'b1;
            cell_o = CELL_ID_WIDTH'(1);
            pos_o[DATA_WIDTH-1 -: CELL_ID_WIDTH] = CELL_ID_WIDTH'(1);
        end
`endif
    end
endmodule

module motion_update_broadcaster #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int CELL_ID_WIDTH = 4,
    parameter int PARTICLE_NUM  = 220,
    parameter int CELL_NUM_X    = 3,
    parameter int CELL_NUM_Y    = 3,
    parameter int CELL_NUM_Z    = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_start,
    output logic [3*CELL_ID_WIDTH-1:0] out_rd_cell,
    output logic [ADDR_WIDTH-1:0]      out_rd_address,
    output logic                       out_rden,
    input  logic [3*DATA_WIDTH-1:0]    in_rd_data,
    output logic                       out_motion_update_enable,
    output logic [3*DATA_WIDTH-1:0]    out_data,
    output logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell,
    output logic                       out_data_valid,
    output logic                       out_busy,
    output logic                       out_done,
    output logic                       out_error
);
    localparam int CW = CELL_ID_WIDTH;
    localparam int DW = DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, COOLDOWN, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cx_q, cy_q, cz_q, cx_d, cy_d, cz_d;
    logic [CW-1:0]   nx, ny, nz;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] rd_raw, rd_cnt;
    logic [1:0]      tmr_q, tmr_d;
    logic            err_q, err_d, clamp_set, clr_err, drop_set, last_cell, rd_ovf;
    logic [1:0]      vld_pipe_q;
    logic [3*DW-1:0] data_q;
    logic [3*CW-1:0] dst_q;

    logic [2:0][DW-1:0] pos_in, pos_wr;
    logic [2:0][CW-1:0] ax_cell;
    logic [2:0]         ax_ok;

    // Axis 0 is x, matching the {posz,posy,posx} packing of the cache word.
    assign pos_in = in_rd_data;
    for (genvar g = 0; g < 3; g++) begin : g_axis
        localparam int N = (g == 0) ? CELL_NUM_X : (g == 1) ? CELL_NUM_Y : CELL_NUM_Z;
        mu_axis_dst #(.DATA_WIDTH(DW), .CELL_ID_WIDTH(CW), .CELL_NUM(N)) u_axis (
            .pos_i(pos_in[g]), .pos_o(pos_wr[g]), .cell_o(ax_cell[g]), .ok_o(ax_ok[g])
        );
    end

    assign rd_raw    = in_rd_data[ADDR_WIDTH-1:0];
    assign rd_ovf    = rd_raw > ADDR_WIDTH'(PARTICLE_NUM - 1);
    assign rd_cnt    = rd_ovf ? ADDR_WIDTH'(PARTICLE_NUM - 1) : rd_raw;
    assign last_cell = (cx_q == CW'(CELL_NUM_X)) && (cy_q == CW'(CELL_NUM_Y)) &&
                       (cz_q == CW'(CELL_NUM_Z));

    always_comb begin
        nx = cx_q;
        ny = cy_q;
        nz = cz_q + 1'b1;
        if (cz_q == CW'(CELL_NUM_Z)) begin
            nz = CW'(1);
            ny = cy_q + 1'b1;
            if (cy_q == CW'(CELL_NUM_Y)) begin
                ny = CW'(1);
                nx = cx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cx_q    <= CW'(1);
            cy_q    <= CW'(1);
            cz_q    <= CW'(1);
            addr_q  <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            cz_q    <= cz_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        cz_d      = cz_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        clamp_set = 1'b0;
        clr_err   = 1'b0;
        case (state_q)
            IDLE: if (in_start) begin
                state_d = RD_CNT;
                cx_d    = CW'(1);
                cy_d    = CW'(1);
                cz_d    = CW'(1);
                clr_err = 1'b1;
            end
            RD_CNT: state_d = WAIT_CNT;
            WAIT_CNT: begin
                cnt_d     = rd_cnt;
                clamp_set = rd_ovf;
                if (rd_cnt == '0) begin
                    if (last_cell) begin
                        state_d = COOLDOWN;
                        tmr_d   = 2'd2;
                    end else begin
                        {cx_d, cy_d, cz_d} = {nx, ny, nz};
                        state_d = RD_CNT;
                    end
                end else begin
                    addr_d  = ADDR_WIDTH'(1);
                    state_d = STREAM;
                end
            end
            STREAM: if (addr_q == cnt_q) begin
                state_d = DRAIN;
                tmr_d   = 2'd1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
            // Two drain cycles cover the memory and destination stages.
            DRAIN: if (tmr_q == '0) begin
                if (last_cell) begin
                    state_d = COOLDOWN;
                    tmr_d   = 2'd2;
                end else begin
                    {cx_d, cy_d, cz_d} = {nx, ny, nz};
                    state_d = RD_CNT;
                end
            end else begin
                tmr_d = tmr_q - 1'b1;
            end
            COOLDOWN: if (tmr_q == '0) state_d = DONE;
                      else tmr_d = tmr_q - 1'b1;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_rden                 = (state_q == RD_CNT) || (state_q == STREAM);
        out_motion_update_enable = (state_q == RD_CNT) || (state_q == WAIT_CNT) ||
                                   (state_q == STREAM) || (state_q == DRAIN);
        out_busy       = state_q != IDLE;
        out_done       = state_q == DONE;
        out_rd_address = (state_q == STREAM) ? addr_q : '0;
        out_rd_cell    = out_motion_update_enable ? {cx_q, cy_q, cz_q} : '0;
    end

    assign drop_set = vld_pipe_q[0] & ~(&ax_ok);
    assign err_d    = clr_err ? 1'b0 : (err_q | clamp_set | drop_set);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            data_q     <= '0;
            dst_q      <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0] & (&ax_ok), state_q == STREAM};
            if (vld_pipe_q[0] && (&ax_ok)) begin
                data_q <= pos_wr;
                dst_q  <= {ax_cell[0], ax_cell[1], ax_cell[2]};
            end
        end
    end

    assign out_data          = data_q;
    assign out_data_dst_cell = dst_q;
    assign out_data_valid    = vld_pipe_q[1];
    assign out_error         = err_q;
endmodule

// File: tb/tb_motion_update_broadcaster.sv
// Randomized bench for motion_update_broadcaster with a cache model and a sweep-level reference.
module tb_motion_update_broadcaster;
    localparam int PN = 220;
    localparam int NC = 27;

    logic        clk = 1'b0, rst_n = 1'b0, in_start = 1'b0;
    logic [95:0] in_rd_data = '0;
    logic [11:0] out_rd_cell, out_data_dst_cell;
    logic [7:0]  out_rd_address;
    logic [95:0] out_data;
    logic        out_rden, out_motion_update_enable, out_data_valid, out_busy, out_done, out_error;

    always #5 clk = ~clk;

    motion_update_broadcaster dut (
        .clk(clk), .rst_n(rst_n), .in_start(in_start),
        .out_rd_cell(out_rd_cell), .out_rd_address(out_rd_address), .out_rden(out_rden),
        .in_rd_data(in_rd_data), .out_motion_update_enable(out_motion_update_enable),
        .out_data(out_data), .out_data_dst_cell(out_data_dst_cell),
        .out_data_valid(out_data_valid), .out_busy(out_busy), .out_done(out_done),
        .out_error(out_error)
    );

    typedef struct { logic [95:0] data; logic [11:0] dst; bit drop; } beat_t;
    typedef struct { int cyc; beat_t b; } pend_t;

    logic [95:0] mem [NC][256];
    beat_t exp_q[$];
    pend_t pend_q[$];
    int    checks = 0, failures = 0, cyc = 0;
    bit    chk_en = 0, en_prev = 0, err_exp = 0;
    int    en_cnt, en_exp, en_fall_cyc, done_cnt, done_cyc, nbeat;
    logic [95:0] last_data, mem_w;
    logic [11:0] last_dst;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cache model: one cycle read latency, garbage when not read.
    initial forever begin
        int x, y, z;
        @(negedge clk);
        mem_w = {$urandom, $urandom, $urandom};
        x = int'(out_rd_cell[11:8]); y = int'(out_rd_cell[7:4]); z = int'(out_rd_cell[3:0]);
        if (out_rden && x >= 1 && x <= 3 && y >= 1 && y <= 3 && z >= 1 && z <= 3)
            mem_w = mem[(x-1)*9 + (y-1)*3 + (z-1)][out_rd_address];
        @(posedge clk);
        #1 in_rd_data = mem_w;
    end

    function automatic beat_t mk_beat(logic [95:0] w);
        beat_t b;
        int c, d;
        b.data = w; b.dst = '0; b.drop = 0;
        for (int ax = 0; ax < 3; ax++) begin
            c = int'(w[ax*32+28 +: 4]);
            d = c;
            if (c >= 1 && c <= 3) d = c;
`ifdef MU_BROADCAST_PERIODIC_WRAP_EN
            else if (c == 0) d = 3;
            else if (c == 4) d = 1;
`endif
            else b.drop = 1;
            b.data[ax*32+28 +: 4] = 4'(d);
            b.dst[(2-ax)*4 +: 4]  = 4'(d);
        end
        return b;
    endfunction

    task automatic build_model();
        exp_q.delete(); en_exp = 0; err_exp = 0;
        for (int idx = 0; idx < NC; idx++) begin
            int cnt;
            cnt = int'(mem[idx][0][7:0]);
            if (cnt > PN - 1) begin cnt = PN - 1; err_exp = 1; end
            en_exp += 2 + ((cnt > 0) ? cnt + 2 : 0);
            for (int a = 1; a <= cnt; a++) begin
                beat_t b;
                b = mk_beat(mem[idx][a]);
                if (b.drop) err_exp = 1;
                exp_q.push_back(b);
            end
        end
    endtask

    // Compare process: every particle read must produce its beat (or drop) exactly 2 cycles later.
    initial forever begin
        pend_t p;
        bit    ev;
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            ev = 0;
            if (pend_q.size() > 0 && pend_q[0].cyc == cyc - 2) begin
                p  = pend_q.pop_front();
                ev = !p.b.drop;
            end
            check("valid", out_data_valid, ev);
            if (ev && out_data_valid) begin
                check("data", out_data, p.b.data);
                check("dst", out_data_dst_cell, p.b.dst);
            end
            if (out_data_valid) begin
                check("valid_while_enabled", out_motion_update_enable, 1);
                nbeat++; last_data = out_data; last_dst = out_data_dst_cell;
            end
            if (out_rden && out_rd_address != 0) begin
                if (exp_q.size() == 0) check("extra_read", out_rd_address, 0);
                else begin
                    p.cyc = cyc; p.b = exp_q.pop_front();
                    pend_q.push_back(p);
                end
            end
            if (out_motion_update_enable) en_cnt++;
            if (en_prev && !out_motion_update_enable) en_fall_cyc = cyc;
            en_prev = out_motion_update_enable;
            if (out_done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    task automatic start_pulse();
        @(posedge clk); #1 in_start = 1;
        @(posedge clk); #1 in_start = 0;
    endtask

    task automatic run_sweep(bit poke);
        build_model();
        pend_q.delete();
        en_cnt = 0; done_cnt = 0; nbeat = 0; en_prev = 0; en_fall_cyc = 0; done_cyc = 0;
        chk_en = 1;
        start_pulse();
        @(negedge clk);
        check("start_enable", out_motion_update_enable, 1);
        check("start_rden", out_rden, 1);
        check("start_cell", out_rd_cell, 12'h111);
        check("start_addr", out_rd_address, 0);
        check("start_busy", out_busy, 1);
        check("start_err_clear", out_error, 0);
        if (poke) begin
            repeat (5) @(posedge clk);
            start_pulse();
        end
        for (int i = 0; i < 5000 && done_cnt == 0; i++) @(negedge clk);
        if (done_cnt == 0) check("done_timeout", done_cnt, 1);
        repeat (8) @(negedge clk);
        check("done_count", done_cnt, 1);
        check("done_after_fall", done_cyc - en_fall_cyc, 3);
        check("enable_cycles", en_cnt, en_exp);
        check("error", out_error, err_exp);
        check("all_read", exp_q.size() + pend_q.size(), 0);
        check("idle_busy", out_busy, 0);
    endtask

    function automatic logic [95:0] mk_pos(logic [3:0] x, logic [3:0] y, logic [3:0] z);
        logic [95:0] w;
        w = {$urandom, $urandom, $urandom};
        w[31:28] = x; w[63:60] = y; w[95:92] = z;
        return w;
    endfunction

    function automatic logic [3:0] rnd_coord();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 4'd0;
        if (r == 1) return 4'd4;
        if (r == 2) return 4'($urandom_range(5, 15));
        return 4'($urandom_range(1, 3));
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < NC; i++)
            for (int a = 0; a < 256; a++)
                mem[i][a] = (a == 0) ? {$urandom, $urandom, $urandom[23:0], 8'd0}
                                     : mk_pos(4'($urandom_range(1, 3)), 4'($urandom_range(1, 3)),
                                              4'($urandom_range(1, 3)));
    endtask

    initial begin
        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_rd_cell", out_rd_cell, 0);
        check("rst_addr", out_rd_address, 0);
        check("rst_rden", out_rden, 0);
        check("rst_enable", out_motion_update_enable, 0);
        check("rst_data", out_data, 0);
        check("rst_dst", out_data_dst_cell, 0);
        check("rst_valid", out_data_valid, 0);
        check("rst_busy", out_busy, 0);
        check("rst_done", out_done, 0);
        check("rst_error", out_error, 0);
        rst_n = 1;

        // Two in-range particles in (1,1,1).
        mem[0][0][7:0] = 8'd2;
        mem[0][1] = mk_pos(4'd2, 4'd1, 4'd3);
        mem[0][2] = mk_pos(4'd2, 4'd1, 4'd3);
        run_sweep(0);
        check("t1_beats", nbeat, 2);
        check("t1_dst", last_dst, 12'h213);
        check("t1_data", last_data, mem[0][2]);
        check("t1_enable", en_cnt, 58);

        // Five particles in (2,2,2).
        clear_mem();
        mem[13][0][7:0] = 8'd5;
        run_sweep(0);
        check("t2_beats", nbeat, 5);
        check("t2_enable", en_cnt, 61);

        // x at 0 and at N+1.
        clear_mem();
        mem[0][0][7:0] = 8'd1;
        mem[0][1] = mk_pos(4'd0, 4'd2, 4'd1);
        run_sweep(0);
`ifdef MU_BROADCAST_PERIODIC_WRAP_EN
        check("x0_beats", nbeat, 1);
        check("x0_dst", last_dst, 12'h321);
        check("x0_rewrite", last_data[31:28], 4'd3);
        check("x0_error", out_error, 0);
`else
        check("x0_beats", nbeat, 0);
        check("x0_error", out_error, 1);
`endif
        mem[0][1] = mk_pos(4'd4, 4'd2, 4'd1);
        run_sweep(0);
`ifdef MU_BROADCAST_PERIODIC_WRAP_EN
        check("x4_beats", nbeat, 1);
        check("x4_dst", last_dst, 12'h121);
        check("x4_rewrite", last_data[31:28], 4'd1);
`else
        check("x4_beats", nbeat, 0);
        check("x4_error", out_error, 1);
`endif

        // Oversized count clamps and flags; next start clears.
        clear_mem();
        mem[26][0][7:0] = 8'd250;
        run_sweep(0);
        check("clamp_beats", nbeat, 219);
        check("clamp_error", out_error, 1);
        clear_mem();
        run_sweep(0);
        check("empty_enable", en_cnt, 54);
        check("empty_error", out_error, 0);

        // Random sweeps; one with a start pulse while busy.
        for (int s = 0; s < 4; s++) begin
            clear_mem();
            for (int i = 0; i < NC; i++) begin
                mem[i][0][7:0] = 8'($urandom_range(0, 6));
                for (int a = 1; a <= 6; a++) mem[i][a] = mk_pos(rnd_coord(), rnd_coord(), rnd_coord());
            end
            run_sweep(s == 2);
        end

        // Reset during STREAM.
        clear_mem();
        mem[0][0][7:0] = 8'd30;
        build_model(); pend_q.delete(); chk_en = 1;
        start_pulse();
        begin
            int i;
            for (i = 0; i < 100 && !(out_rden && out_rd_address >= 8'd3); i++) @(negedge clk);
            check("reach_stream", out_rd_address >= 8'd3, 1);
        end
        @(posedge clk);
        #3 rst_n = 0; chk_en = 0;
        #1;
        check("midrst_enable", out_motion_update_enable, 0);
        check("midrst_valid", out_data_valid, 0);
        check("midrst_busy", out_busy, 0);
        check("midrst_rden", out_rden, 0);
        check("midrst_done", out_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        mem[0][0][7:0] = 8'd3;
        run_sweep(0);
        check("post_rst_beats", nbeat, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
